// File: rtl/multdiv_pkg.sv
`default_nettype none
// ============================================================================
// Module  : multdiv_pkg
// Brief   : Shared types and constants for the iterative multiply/divide unit
// Revision: 1.0  initial release
// ============================================================================
package multdiv_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int          MD_ITERS = 32;
  localparam logic [31:0] INT_MIN  = 32'h8000_0000;

  // |INT_MIN| stays 0x80000000, which is exactly the unsigned magnitude we want
  function automatic logic [31:0] abs32(input logic [31:0] v);
    return v[31] ? (32'd0 - v) : v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/multdiv_if.sv
`default_nettype none
// ============================================================================
// Module  : multdiv_if
// Brief   : Processor <-> multiply/divide request/response bundle
// Revision: 1.0  initial release
// ============================================================================
interface multdiv_if;
  logic [31:0] data_operandA;
  logic [31:0] data_operandB;
  logic        ctrl_MULT;
  logic        ctrl_DIV;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;

  modport master (
    output data_operandA, data_operandB, ctrl_MULT, ctrl_DIV,
    input  data_result, data_exception, data_resultRDY
  );

  modport slave (
    input  data_operandA, data_operandB, ctrl_MULT, ctrl_DIV,
    output data_result, data_exception, data_resultRDY
  );
endinterface
`default_nettype wire

// File: rtl/cla_full_adder.sv
`default_nettype none
// ============================================================================
// Module  : cla_full_adder
// Brief   : 32-bit adder in generate/propagate form with carry out
// Revision: 1.0  initial release
// ============================================================================
module cla_full_adder (
  input  wire logic [31:0] i_a,
  input  wire logic [31:0] i_b,
  input  wire logic        i_cin,
  output logic      [31:0] o_sum,
  output logic             o_cout
);
  logic [31:0] w_g;
  logic [31:0] w_p;
  logic [32:0] w_c;

  assign w_g    = i_a & i_b;
  assign w_p    = i_a ^ i_b;
  assign w_c[0] = i_cin;

  for (genvar gi = 0; gi < 32; gi++) begin : g_carry
    assign w_c[gi+1] = w_g[gi] | (w_p[gi] & w_c[gi]);
  end

  assign o_sum  = w_p ^ w_c[31:0];
  assign o_cout = w_c[32];
endmodule
`default_nettype wire

// File: rtl/multdiv_step.sv
`default_nettype none
// ============================================================================
// Module  : multdiv_step
// Brief   : One combinational iteration: shift-add multiply or restoring divide
// Revision: 1.0  initial release
// ============================================================================
module multdiv_step (
  input  wire logic        i_div,
  input  wire logic [31:0] i_hi,
  input  wire logic [31:0] i_lo,
  input  wire logic [31:0] i_b,
  output logic      [31:0] o_hi,
  output logic      [31:0] o_lo
);
  logic [31:0] w_add_a;
  logic [31:0] w_add_b;
  logic        w_cin;
  logic [31:0] w_sum;
  logic        w_cout;
  logic        w_fits;

  // Divide: {hi,lo} shifts left one bit, then trial-subtract the divisor from
  // the 33-bit partial remainder {hi, lo[31]}.
  always_comb begin
    if (i_div) begin
      w_add_a = {i_hi[30:0], i_lo[31]};
      w_add_b = ~i_b;
      w_cin   = 1'b1;
    end else begin
      w_add_a = i_hi;
      w_add_b = i_lo[0] ? i_b : 32'd0;
      w_cin   = 1'b0;
    end
  end

  cla_full_adder u_add (
    .i_a    (w_add_a),
    .i_b    (w_add_b),
    .i_cin  (w_cin),
    .o_sum  (w_sum),
    .o_cout (w_cout)
  );

  // Remainder bit 32 set, or no borrow, means the divisor fits
  assign w_fits = i_hi[31] | w_cout;

  always_comb begin
    if (i_div) begin
      o_hi = w_fits ? w_sum : w_add_a;
      o_lo = {i_lo[30:0], w_fits};
    end else begin
      o_hi = {w_cout, w_sum[31:1]};
      o_lo = {w_sum[0], i_lo[31:1]};
    end
  end
endmodule
`default_nettype wire

// File: rtl/multdiv.sv
`default_nettype none
// ============================================================================
// Module  : multdiv
// Brief   : Iterative signed 32-bit multiply/divide, 32 iterations per op
// Revision: 1.0  initial release
// ============================================================================
module multdiv
  import multdiv_pkg::*;
(
  input wire logic clock,
  input wire logic reset,
  multdiv_if.slave bus
);
  state_t      r_state;
  logic [4:0]  r_cnt;
  logic        r_div;
  logic        r_sign;
  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic [31:0] r_b;
  logic [31:0] r_result;
  logic        r_exc;
  logic        r_rdy;

  logic        w_start;
  logic [31:0] w_hi_nxt;
  logic [31:0] w_lo_nxt;
  logic [63:0] w_prod_s;
  logic [31:0] w_quot_s;
  logic [31:0] w_res;
  logic        w_exc;

  assign w_start = bus.ctrl_MULT | bus.ctrl_DIV;

  multdiv_step u_step (
    .i_div (r_div),
    .i_hi  (r_hi),
    .i_lo  (r_lo),
    .i_b   (r_b),
    .o_hi  (w_hi_nxt),
    .o_lo  (w_lo_nxt)
  );

  // Finalise from the last iteration's output so the result lands on the DONE edge
  always_comb begin
    w_prod_s = r_sign ? (64'd0 - {w_hi_nxt, w_lo_nxt}) : {w_hi_nxt, w_lo_nxt};
    w_quot_s = r_sign ? (32'd0 - w_lo_nxt) : w_lo_nxt;
    if (r_div) begin
      if (r_b == 32'd0) begin
        w_res = 32'd0;
        w_exc = 1'b1;
      end else begin
        // Only |INT_MIN / -1| yields a positive quotient with bit 31 set
        w_res = w_quot_s;
        w_exc = ~r_sign & w_lo_nxt[31];
      end
    end else begin
      w_res = w_prod_s[31:0];
      w_exc = (w_prod_s[63:32] != {32{w_prod_s[31]}});
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state  <= IDLE;
      r_cnt    <= 5'd0;
      r_div    <= 1'b0;
      r_sign   <= 1'b0;
      r_hi     <= 32'd0;
      r_lo     <= 32'd0;
      r_b      <= 32'd0;
      r_result <= 32'd0;
      r_exc    <= 1'b0;
      r_rdy    <= 1'b0;
    end else begin
      r_rdy <= 1'b0;
      if (w_start) begin
        r_state <= BUSY;
        r_cnt   <= 5'd0;
        r_div   <= ~bus.ctrl_MULT;
        r_sign  <= bus.data_operandA[31] ^ bus.data_operandB[31];
        r_hi    <= 32'd0;
        r_lo    <= abs32(bus.data_operandA);
        r_b     <= abs32(bus.data_operandB);
      end else begin
        case (r_state)
          BUSY: begin
            r_hi  <= w_hi_nxt;
            r_lo  <= w_lo_nxt;
            r_cnt <= r_cnt + 5'd1;
            if (r_cnt == 5'(MD_ITERS - 1)) begin
              r_state  <= DONE;
              r_rdy    <= 1'b1;
              r_result <= w_res;
              r_exc    <= w_exc;
            end
          end
          DONE:    r_state <= IDLE;
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign bus.data_result    = r_result;
  assign bus.data_exception = r_exc;
  assign bus.data_resultRDY = r_rdy;
endmodule
`default_nettype wire
